echo_emu: RTL

// - Synthesizable responder model of the ultrasonic ranging sensor (trig in, echo out).
// - Stands in for the physical sensor on s1_trig/s1_echo for hardware-in-loop and bench tests of the measurement path.
// - Accepts a trigger pulse and waits a fixed burst delay.
// - Then drives an echo pulse whose width (us) encodes the configured distance.
// - Clocked by clk_sys; timed by the 1 us strobe pluse_us.

---
 rtl/echo_emu_if.sv | 31 +++
 rtl/echo_emu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/echo_emu_if.sv
// echo_emu_if: trigger/echo, configuration and microsecond strobe signals of the sensor emulator.
// The master modport is the measurement side; the slave modport is the emulator.
interface echo_emu_if;
    logic        pluse_us;
    logic        trig;
    logic [15:0] cfg_width;
    logic        cfg_vld;
    logic        echo;
    logic        busy;
    logic        err_short;

    modport master (
        output pluse_us,
        output trig,
        output cfg_width,
        output cfg_vld,
        input  echo,
        input  busy,
        input  err_short
    );

    modport slave (
        input  pluse_us,
        input  trig,
        input  cfg_width,
        input  cfg_vld,
        output echo,
        output busy,
        output err_short
    );
endinterface

// File: rtl/echo_emu.sv
// echo_emu: synthesizable responder model of an ultrasonic ranging sensor (trig in, echo out).
// Build macro ECHO_EMU_JITTER_EN adds 0..3 us of LFSR-driven echo width jitter per frame.
module echo_emu #(
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned DLY_US      = 200,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic      clk_sys,
    input  logic      rst_n,
    echo_emu_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [15:0] TRIG_MIN_C  = 16'(TRIG_MIN_US);
    localparam logic [15:0] DLY_LAST_C  = 16'(DLY_US - 1);
    localparam logic [15:0] TIMEOUT_C   = 16'(TIMEOUT_US);
    localparam logic [15:0] HOLD_LAST_C = 16'(HOLDOFF_US - 1);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [15:0] cnt_inc_s;
    logic [15:0] width_reg_r;
    logic [15:0] eff_width_r;
    logic [15:0] eff_width_s;
    logic [15:0] src_width_s;
    logic        trig_meta_r;
    logic        trig_sync_r;
    logic        trig_prev_r;
    logic        trig_rise_s;
    logic        trig_fall_s;
    logic        echo_r;
    logic        echo_s;
    logic        busy_r;
    logic        busy_s;
    logic        err_short_r;
    logic        err_short_s;
    logic        echo_entry_s;
    logic [1:0]  jit_s;

    // Two-flop synchronizer for the asynchronous trig pad, plus one stage of edge history
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta_r <= 1'b0;
            trig_sync_r <= 1'b0;
            trig_prev_r <= 1'b0;
        end else begin
            trig_meta_r <= bus.trig;
            trig_sync_r <= trig_meta_r;
            trig_prev_r <= trig_sync_r;
        end
    end

    assign trig_rise_s  = trig_sync_r & ~trig_prev_r;
    assign trig_fall_s  = ~trig_sync_r & trig_prev_r;
    assign cnt_inc_s    = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
    assign src_width_s  = bus.cfg_vld ? bus.cfg_width : width_reg_r;
    assign echo_entry_s = (state_r == ST_WAIT) && bus.pluse_us && (cnt_r == DLY_LAST_C);

`ifdef ECHO_EMU_JITTER_EN
    logic [15:0] lfsr_r;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // LFSR steps once per frame; the value held before the step sets this frame's jitter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
        end else if (echo_entry_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign jit_s = lfsr_r[1:0];
`else
    assign jit_s = 2'd0;
`endif

    // Clamp a zero or oversize width to the no-object timeout, then add jitter
    always_comb begin
        eff_width_s = TIMEOUT_C;
        if ((src_width_s != 16'd0) && (src_width_s <= TIMEOUT_C)) begin
            eff_width_s = src_width_s;
        end else begin
            eff_width_s = TIMEOUT_C;
        end
        eff_width_s = eff_width_s + {14'd0, jit_s};
    end

    // Configured width and the per-frame shadow copy taken on echo entry
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            width_reg_r <= TIMEOUT_C;
            eff_width_r <= TIMEOUT_C;
        end else begin
            width_reg_r <= bus.cfg_vld ? bus.cfg_width : width_reg_r;
            eff_width_r <= echo_entry_s ? eff_width_s : eff_width_r;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            echo_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_short_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            echo_r      <= echo_s;
            busy_r      <= busy_s;
            err_short_r <= err_short_s;
        end
    end

    // Next-state logic; counters only advance on microsecond strobes
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        echo_s      = echo_r;
        busy_s      = busy_r;
        err_short_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_rise_s) begin
                    state_s = ST_TRIG_HI;
                    cnt_s   = 16'd0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRIG_HI: begin
                if (trig_fall_s) begin
                    cnt_s = 16'd0;
                    if (cnt_r >= TRIG_MIN_C) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s     = ST_IDLE;
                        err_short_s = 1'b1;
                        busy_s      = 1'b0;
                    end
                end else if (trig_sync_r && bus.pluse_us) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_WAIT: begin
                if (echo_entry_s) begin
                    state_s = ST_ECHO;
                    cnt_s   = 16'd0;
                    echo_s  = 1'b1;
                end else if (bus.pluse_us) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_ECHO: begin
                if (bus.pluse_us && (cnt_r == (eff_width_r - 16'd1))) begin
                    state_s = ST_HOLDOFF;
                    cnt_s   = 16'd0;
                    echo_s  = 1'b0;
                end else if (bus.pluse_us) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_HOLDOFF: begin
                if (bus.pluse_us && (cnt_r == HOLD_LAST_C)) begin
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                    busy_s  = 1'b0;
                end else if (bus.pluse_us) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
                echo_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign bus.echo      = echo_r;
    assign bus.busy      = busy_r;
    assign bus.err_short = err_short_r;

endmodule
